// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master: configurable word width, SCLK divider and CPOL/CPHA mode.
// Define SPI_LSB_FIRST_EN to shift both MOSI and MISO LSB first (default MSB first).
module spi_master_cfg #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DATA_W-1:0]            datain,
  input  logic                         miso,
  output logic                         spi_cs_L,
  output logic                         spi_sclk,
  output logic                         spi_data,
  output logic [DATA_W-1:0]            dataout,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DATA_W+1)-1:0]  counter
);

  localparam int CNT_W = $clog2(DATA_W+1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TOG_W = $clog2(2*DATA_W+1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV-1);
  localparam logic [TOG_W-1:0] TOG_LAST   = TOG_W'(2*DATA_W-1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, HOLD, DONE} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [TOG_W-1:0]    tog_q, tog_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick;
  logic                leading;
  logic                do_sample;
  logic                do_shift;

  // Bit-order steering: first bit of a word, the word after removing it, and rx fill.
  logic                din_first;
  logic [DATA_W-1:0]   din_rest;
  logic                tx_first;
  logic [DATA_W-1:0]   tx_rest;
  logic [DATA_W-1:0]   rx_in;

`ifdef SPI_LSB_FIRST_EN
  assign din_first = datain[0];
  assign din_rest  = {1'b0, datain[DATA_W-1:1]};
  assign tx_first  = tx_q[0];
  assign tx_rest   = {1'b0, tx_q[DATA_W-1:1]};
  assign rx_in     = {miso, rx_q[DATA_W-1:1]};
`else
  assign din_first = datain[DATA_W-1];
  assign din_rest  = {datain[DATA_W-2:0], 1'b0};
  assign tx_first  = tx_q[DATA_W-1];
  assign tx_rest   = {tx_q[DATA_W-2:0], 1'b0};
  assign rx_in     = {rx_q[DATA_W-2:0], miso};
`endif

  assign tick    = (div_q == '0);
  assign leading = ~tog_q[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      tog_q   <= '0;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tog_q   <= tog_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LEAD;
      LEAD:    if (tick) state_d = SHIFT;
      SHIFT:   if (tick && (tog_q == TOG_LAST)) state_d = HOLD;
      HOLD:    if (tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d     = div_q;
    tog_d     = tog_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          div_d = DIV_RELOAD;
          tog_d = '0;
          cnt_d = '0;
          // CPHA=0 must present bit 0 before the first (sampling) leading edge.
          if (!CPHA) begin
            mosi_d = din_first;
            tx_d   = din_rest;
          end else begin
            tx_d   = datain;
          end
        end
      end
      LEAD, SHIFT: begin
        if (tick) begin
          div_d  = DIV_RELOAD;
          tog_d  = tog_q + 1'b1;
          sclk_d = ~sclk_q;
          if (!CPHA) begin
            do_sample = leading;
            do_shift  = !leading && (tog_q != TOG_LAST);
          end else begin
            do_shift  = leading;
            do_sample = !leading;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          dout_d = rx_q;
          cnt_d  = '0;
        end else begin
          div_d  = div_q - 1'b1;
        end
      end
      default: ;
    endcase
    if (do_shift) begin
      mosi_d = tx_first;
      tx_d   = tx_rest;
    end
    if (do_sample) begin
      rx_d  = rx_in;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    busy     = (state_q == LEAD) || (state_q == SHIFT) || (state_q == HOLD);
    spi_cs_L = ~busy;
    done     = (state_q == DONE);
  end

  assign spi_sclk = sclk_q;
  assign spi_data = mosi_q;
  assign dataout  = dout_q;
  assign counter  = cnt_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: mode 0 (CLK_DIV=2, MOSI looped to MISO) and
// mode 3 (CLK_DIV=1, MISO driven by a bench slave); bit order follows SPI_LSB_FIRST_EN.
module tb_spi_master_cfg;

  localparam int W    = 16;
  localparam int DIV0 = 2;
  localparam int DIV3 = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start3 = 1'b0;
  logic [15:0] datain0 = '0, datain3 = '0;
  logic        miso0, miso3 = 1'b0;

  logic        cs0, sclk0, mosi0, busy0, done0;
  logic        cs3, sclk3, mosi3, busy3, done3;
  logic [15:0] dout0, dout3;
  logic [4:0]  cnt0, cnt3;

  assign miso0 = mosi0;

  always #5 clk = ~clk;

  spi_master_cfg #(.DATA_W(W), .CLK_DIV(DIV0), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .datain(datain0), .miso(miso0),
    .spi_cs_L(cs0), .spi_sclk(sclk0), .spi_data(mosi0), .dataout(dout0),
    .busy(busy0), .done(done0), .counter(cnt0));

  spi_master_cfg #(.DATA_W(W), .CLK_DIV(DIV3), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .datain(datain3), .miso(miso3),
    .spi_cs_L(cs3), .spi_sclk(sclk3), .spi_data(mosi3), .dataout(dout3),
    .busy(busy3), .done(done3), .counter(cnt3));

  // View of whichever instance the current transaction targets.
  logic        sel = 1'b0;
  logic        m_cs, m_sclk, m_mosi, m_busy, m_done;
  logic [15:0] m_dout;
  logic [4:0]  m_cnt;
  assign m_cs   = sel ? cs3   : cs0;
  assign m_sclk = sel ? sclk3 : sclk0;
  assign m_mosi = sel ? mosi3 : mosi0;
  assign m_busy = sel ? busy3 : busy0;
  assign m_done = sel ? done3 : done0;
  assign m_dout = sel ? dout3 : dout0;
  assign m_cnt  = sel ? cnt3  : cnt0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [15:0] w);
    if (sel) begin
      start3  = s;
      datain3 = w;
    end else begin
      start0  = s;
      datain0 = w;
    end
  endtask

  // Bit j (0 = first on the wire) of a word in transmission order.
  function automatic logic wire_bit(input logic [15:0] w, input int j);
`ifdef SPI_LSB_FIRST_EN
    return w[j];
`else
    return w[15-j];
`endif
  endfunction

  task automatic run_xfer(input string tag, input logic s, input logic [15:0] word,
                          input logic [15:0] rxw, input int poke_edge, input int rst_edge);
    int          div, done_edge, ndone, nrise, badrise, nfall, maxcnt;
    logic [15:0] mw;
    logic        prev_sclk, first_bit, got_first, b;
    sel       = s;
    div       = s ? DIV3 : DIV0;
    done_edge = -1;
    ndone     = 0;
    nrise     = 0;
    badrise   = 0;
    nfall     = 0;
    maxcnt    = 0;
    mw        = '0;
    first_bit = 1'b0;
    got_first = 1'b0;
    prev_sclk = s ? sclk3 : sclk0;
    drive(1'b1, word);
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        drive(1'b0, word);
        chk({tag, "_cs_low"}, 32'(m_cs), 32'd0);
        chk({tag, "_busy"}, 32'(m_busy), 32'd1);
      end
      if (e == poke_edge)     drive(1'b1, 16'h9B63);
      if (e == poke_edge + 1) drive(1'b0, 16'h9B63);
      if (e == rst_edge) begin
        reset = 1'b0;
        #1;
        chk({tag, "_rst_cs"},   32'(m_cs),   32'd1);
        chk({tag, "_rst_sclk"}, 32'(m_sclk), 32'(s));
        chk({tag, "_rst_busy"}, 32'(m_busy), 32'd0);
        chk({tag, "_rst_cnt"},  32'(m_cnt),  32'd0);
        chk({tag, "_rst_dout"}, 32'(m_dout), 32'd0);
        chk({tag, "_rst_done"}, 32'(m_done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("xfer %s: aborted by reset at edge %0d", tag, e);
        return;
      end
      if (m_sclk && !prev_sclk) begin
        if (e != 1 + div * (2 * nrise + 1 + int'(s))) badrise++;
        b = m_mosi;
        if (!got_first) begin
          first_bit = b;
          got_first = 1'b1;
        end
`ifdef SPI_LSB_FIRST_EN
        mw = {b, mw[15:1]};
`else
        mw = {mw[14:0], b};
`endif
        nrise++;
      end
      if (!m_sclk && prev_sclk) begin
        if (s && nfall < 16) miso3 = wire_bit(rxw, nfall);
        nfall++;
      end
      prev_sclk = m_sclk;
      if (int'(m_cnt) > maxcnt) maxcnt = int'(m_cnt);
      if (m_done) begin
        ndone++;
        if (done_edge < 0) begin
          done_edge = e;
          chk({tag, "_dout"}, 32'(m_dout), 32'(rxw));
          chk({tag, "_cnt_at_done"}, 32'(m_cnt), 32'd0);
        end
      end
      if (done_edge >= 0 && e >= done_edge + 2) break;
    end
    chk({tag, "_done_edge"}, 32'(done_edge), 32'(1 + div * (2 * W + 1)));
    chk({tag, "_ndone"}, 32'(ndone), 32'd1);
    chk({tag, "_nrise"}, 32'(nrise), 32'd16);
    chk({tag, "_rise_timing"}, 32'(badrise), 32'd0);
    chk({tag, "_mosi_word"}, 32'(mw), 32'(word));
    chk({tag, "_first_bit"}, 32'(first_bit), 32'(wire_bit(word, 0)));
    chk({tag, "_maxcnt"}, 32'(maxcnt), 32'd16);
    chk({tag, "_cs_idle"}, 32'(m_cs), 32'd1);
    chk({tag, "_sclk_idle"}, 32'(m_sclk), 32'(s));
    $display("xfer %s: tx=%h rx=%h done_edge=%0d dout=%h", tag, word, rxw, done_edge, m_dout);
  endtask

  task automatic run_b2b();
    int ndone, csh, gap, nlow;
    ndone = 0;
    csh   = 0;
    gap   = -1;
    nlow  = 0;
    sel   = 1'b0;
    drive(1'b1, 16'hA265);
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) datain0 = 16'h7564;
      if (m_cs) begin
        csh++;
      end else if (csh > 0 || e == 1) begin
        nlow++;
        if (nlow == 2) begin
          gap    = csh;
          start0 = 1'b0;
        end
        csh = 0;
      end
      if (m_done) begin
        ndone++;
        chk($sformatf("b2b_dout%0d", ndone), 32'(m_dout), ndone == 1 ? 32'h0000A265 : 32'h00007564);
        if (ndone == 2) break;
      end
    end
    start0 = 1'b0;
    chk("b2b_ndone", 32'(ndone), 32'd2);
    chk("b2b_cs_gap", 32'(gap), 32'd2);
    $display("xfer b2b: A265 then 7564, done pulses=%0d cs high gap=%0d", ndone, gap);
  endtask

  initial begin
    #1;
    reset = 1'b0;
    #1;
    chk("rst_cs0",   32'(cs0),   32'd1);
    chk("rst_sclk0", 32'(sclk0), 32'd0);
    chk("rst_mosi0", 32'(mosi0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_dout0", 32'(dout0), 32'd0);
    chk("rst_cnt0",  32'(cnt0),  32'd0);
    chk("rst_cs3",   32'(cs3),   32'd1);
    chk("rst_sclk3", 32'(sclk3), 32'd1);
    chk("rst_busy3", 32'(busy3), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_xfer("t1_mode0",  1'b0, 16'hA569, 16'hA569, -10, -1);
    run_xfer("t2_mode3",  1'b1, 16'hC3A5, 16'h2563, -10, -1);
    run_xfer("t3_ignore", 1'b0, 16'h5A3C, 16'h5A3C, 20,  -1);
    run_xfer("t4_reset",  1'b0, 16'hF00F, 16'hF00F, -10, 30);
    run_xfer("t4_after",  1'b0, 16'h6A61, 16'h6A61, -10, -1);
    run_b2b();
    @(posedge clk);
    #1;
    run_xfer("t6_0001",   1'b0, 16'h0001, 16'h0001, -10, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
